// File: rtl/v60_mem_responder.sv
// Memory-side responder for the V60 core: word-organised SRAM with a programmable
// wait-state count, little-endian byte lanes and bus-error reporting.
module v60_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned WAIT_RESET = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  bus_error,
    input  logic [3:0]            wait_cfg,
    input  logic                  wait_ld,
    output logic [7:0]            err_count
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned AW    = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [3:0]            cnt;
    logic [3:0]            wait_q;
    logic                  req_wr;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  cur_wr;
    logic [1:0]            cur_size;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_err;
    logic [AW-1:0]         cur_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_lane;
    logic                  enter_resp;
    logic                  do_write;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    // In IDLE the request is still on the inputs; afterwards it lives in the latches.
    always_comb begin
        cur_wr   = req_wr;
        cur_size = req_size;
        cur_addr = req_addr;
        if (state == S_IDLE) begin
            cur_wr   = mem_wr;
            cur_size = mem_size;
            cur_addr = mem_addr;
        end
    end

    always_comb begin
        cur_err = 1'b0;
        if (cur_size == 2'b11)                              cur_err = 1'b1;
        if (cur_size == 2'b01 && cur_addr[0])               cur_err = 1'b1;
        if (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)    cur_err = 1'b1;
        if (cur_addr[ADDR_WIDTH-1:2] >= IDX_W'(MEM_WORDS))  cur_err = 1'b1;
    end

    assign cur_idx = cur_addr[AW+1:2];

    // Right-justified, zero-extended read lane.
    always_comb begin
        rd_word  = mem[cur_idx];
        rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
        case (cur_size)
            2'b00:   rd_lane = {24'd0, rd_shift[7:0]};
            2'b01:   rd_lane = {16'd0, rd_shift[15:0]};
            default: rd_lane = rd_word;
        endcase
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = req_wdata;
        case (req_size)
            2'b00: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (mem_req) next_state = (wait_q == 4'd0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!mem_req)          next_state = S_IDLE;
                else if (cnt == 4'd1)  next_state = S_RESP;
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        enter_resp = (next_state == S_RESP);
        do_write   = (state == S_RESP) && req_wr && !cur_err && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            wait_q <= 4'(WAIT_RESET);
        end else begin
            state <= next_state;
            if (wait_ld) wait_q <= wait_cfg;
            if (state == S_IDLE && mem_req) cnt <= wait_q;
            else if (state == S_WAIT)       cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && mem_req) begin
            req_wr    <= mem_wr;
            req_size  <= mem_size;
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
        end
    end

    // Response registers: data is captured on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            bus_error <= 1'b0;
            mem_rdata <= '0;
            err_count <= 8'd0;
        end else begin
            mem_ready <= enter_resp;
            bus_error <= enter_resp && cur_err;
            if (enter_resp) begin
                if (cur_err) begin
                    mem_rdata <= '0;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end else if (!cur_wr) begin
                    mem_rdata <= rd_lane;
                end
            end
        end
    end

    // Array is never reset; writes land at the end of the RESP cycle.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[req_addr[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule
